// File: rtl/tile_seq_driver.sv
// Command sequencer for the single-PE systolic tile: preload, stream K a/b beats, drain, respond.
// Optional TILE_SEQ_PERF_EN adds the perf_bubbles stall counter output.
module tile_seq_driver #(
    parameter int PE_LATENCY = 1,
    parameter int K_W        = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [K_W-1:0] cmd_k,
    input  logic [15:0]    cmd_d,
    input  logic           ab_valid,
    output logic           ab_ready,
    input  logic [7:0]     ab_a,
    input  logic [7:0]     ab_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [15:0]    res_c,
    output logic           busy,
    output logic [7:0]     tile_in_a,
    output logic [7:0]     tile_in_b,
    output logic [15:0]    tile_in_d,
    output logic           tile_in_propagate,
    input  logic [15:0]    tile_out_c
`ifdef TILE_SEQ_PERF_EN
    ,
    output logic [15:0]    perf_bubbles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_STREAM,
        S_DRAIN,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT    = 4'(PE_LATENCY);
    localparam logic [3:0] LAT_M1 = 4'(PE_LATENCY - 1);

    state_t         r_state;
    state_t         w_next;
    logic [K_W-1:0] r_rem;
    logic [3:0]     r_drain;
    logic           w_cmd_hs;
    logic           w_ab_hs;
    logic           w_last;
    logic           w_drain_done;

    assign cmd_ready    = (r_state == S_IDLE);
    assign ab_ready     = (r_state == S_STREAM);
    assign res_valid    = (r_state == S_RESP);
    assign busy         = (r_state != S_IDLE);
    assign w_cmd_hs     = cmd_valid && cmd_ready;
    assign w_ab_hs      = ab_valid && ab_ready;
    assign w_last       = w_ab_hs && (r_rem == K_W'(1));
    assign w_drain_done = (r_state == S_DRAIN) && (r_drain == 4'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_cmd_hs) w_next = S_PRELOAD;
            S_PRELOAD: w_next = (r_rem == '0) ? S_DRAIN : S_STREAM;
            S_STREAM:  if (w_last) w_next = S_DRAIN;
            S_DRAIN:   if (w_drain_done) w_next = S_RESP;
            S_RESP:    if (res_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_rem             <= '0;
            r_drain           <= '0;
            res_c             <= '0;
            tile_in_a         <= '0;
            tile_in_b         <= '0;
            tile_in_d         <= '0;
            tile_in_propagate <= 1'b0;
        end else begin
            r_state   <= w_next;
            // Tile inputs are zero unless a preload or an accepted beat is being presented.
            tile_in_a <= w_ab_hs ? ab_a : 8'd0;
            tile_in_b <= w_ab_hs ? ab_b : 8'd0;
            tile_in_d <= w_cmd_hs ? cmd_d : 16'd0;
            if (w_cmd_hs) begin
                tile_in_propagate <= ~tile_in_propagate;
                r_rem             <= cmd_k;
            end else if (w_ab_hs) begin
                r_rem <= r_rem - K_W'(1);
            end
            // Capture lands PE_LATENCY cycles after the last beat is on the tile; the preload
            // beat is already one cycle old on entry to DRAIN, hence the shorter count.
            if (r_state == S_PRELOAD)
                r_drain <= LAT_M1;
            else if (w_last)
                r_drain <= LAT;
            else if (r_state == S_DRAIN && r_drain != 4'd0)
                r_drain <= r_drain - 4'd1;
            if (w_drain_done)
                res_c <= tile_out_c;
        end
    end

`ifdef TILE_SEQ_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset_n || w_cmd_hs)
            perf_bubbles <= '0;
        else if (r_state == S_STREAM && !ab_valid && perf_bubbles != 16'hFFFF)
            perf_bubbles <= perf_bubbles + 16'd1;
    end
`endif

endmodule
